// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy pixel pipeline.
// Geometry is kept in signed 12-bit screen coordinates so pipes can slide off the left edge.
package flappy_pkg;

    localparam int H_RES        = 800;
    localparam int V_RES        = 600;
    localparam int N_PIPES      = 3;
    localparam int PIPE_W       = 80;
    localparam int PIPE_SPACING = 300;
    localparam int GAP_H        = 160;
    localparam int GAP_MIN      = 80;
    localparam int LIP_H        = 16;
    localparam int SPEED        = 2;
    localparam int BIRD_X       = 200;

    localparam logic [11:0] PIPE_COLOR = 12'h0A0;
    localparam logic [11:0] LIP_COLOR  = 12'h070;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } game_st_t;

    typedef logic signed [11:0] xpos_t;

    localparam xpos_t SPEED_X    = xpos_t'(SPEED);
    localparam xpos_t PIPE_W_X   = xpos_t'(PIPE_W);
    localparam xpos_t ROTATE_X   = xpos_t'(N_PIPES * PIPE_SPACING);
    localparam xpos_t GAP_H_X    = xpos_t'(GAP_H);
    localparam xpos_t GAP_MIN_X  = xpos_t'(GAP_MIN);
    localparam xpos_t LIP_H_X    = xpos_t'(LIP_H);
    localparam xpos_t BIRD_X_X   = xpos_t'(BIRD_X);
    localparam xpos_t GAP_INIT_X = xpos_t'((V_RES - GAP_H) / 2);

    function automatic xpos_t x_init(input int idx);
        return xpos_t'(H_RES + idx * PIPE_SPACING);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), free-running while en_i is high.
module lfsr16
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [15:0] q_o
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
        end else begin
            q_d = q_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/draw_pipes.sv
// Overlays scrolling pipe pairs on the background pixel stream with a 2-clock latency.
// Owns pipe positions, gap heights, the game state, the score event and the pipe flag.
module draw_pipes
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        freeze_i,
    input  logic [10:0] vin_hcount_i,
    input  logic [10:0] vin_vcount_i,
    input  logic        vin_hsync_i,
    input  logic        vin_vsync_i,
    input  logic        vin_hblnk_i,
    input  logic        vin_vblnk_i,
    input  logic [11:0] rgb_in_i,
    output logic [10:0] vout_hcount_o,
    output logic [10:0] vout_vcount_o,
    output logic        vout_hsync_o,
    output logic        vout_vsync_o,
    output logic        vout_hblnk_o,
    output logic        vout_vblnk_o,
    output logic [11:0] rgb_out_o,
    output logic        pipe_px_o,
    output logic        score_pulse_o
);

    game_st_t           state_q;
    xpos_t              x_q   [N_PIPES];
    xpos_t              gap_q [N_PIPES];
    xpos_t              x_d   [N_PIPES];
    xpos_t              gap_d [N_PIPES];
    logic [N_PIPES-1:0] score_hit_s;
    logic [N_PIPES-1:0] lip_s;
    logic [N_PIPES-1:0] body_s;
    logic [15:0]        lfsr_s;
    logic               lfsr_unused_s;
    logic               frame_tick_s;
    logic               advance_s;
    logic               reinit_s;
    logic               score_pulse_q;
    xpos_t              h_s;
    xpos_t              v_s;

    logic [10:0] s1_hcount_q, s1_vcount_q;
    logic        s1_hsync_q, s1_vsync_q, s1_hblnk_q, s1_vblnk_q;
    logic [11:0] s1_rgb_q;
    logic        s1_lip_q, s1_body_q;

    logic [10:0] s2_hcount_q, s2_vcount_q;
    logic        s2_hsync_q, s2_vsync_q, s2_hblnk_q, s2_vblnk_q;
    logic [11:0] s2_rgb_q;
    logic        s2_px_q;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en_i (1'b1),
        .q_o  (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s[15:8];

    // Positions move only on the first clock of the vertical blanking interval.
    assign frame_tick_s = (vin_vcount_i == 11'(V_RES)) && (vin_hcount_i == 11'd0);
    assign advance_s    = (state_q == RUN) && frame_tick_s;
    assign reinit_s     = (state_q == FREEZE) && start_i;
    assign h_s          = $signed({1'b0, vin_hcount_i});
    assign v_s          = $signed({1'b0, vin_vcount_i});

    for (genvar i = 0; i < N_PIPES; i++) begin : g_pipe
        xpos_t moved_s;
        xpos_t gap_bot_s;
        logic  wrap_s;
        logic  hit_x_s;
        logic  lip_band_s;

        assign moved_s   = x_q[i] - SPEED_X;
        assign wrap_s    = (moved_s + PIPE_W_X) <= 12'sd0;
        assign x_d[i]    = wrap_s ? (moved_s + ROTATE_X) : moved_s;
        assign gap_d[i]  = wrap_s ? (GAP_MIN_X + $signed({4'h0, lfsr_s[7:0]})) : gap_q[i];
        assign score_hit_s[i] = ((x_q[i] + PIPE_W_X) > BIRD_X_X) && ((moved_s + PIPE_W_X) <= BIRD_X_X);

        assign gap_bot_s  = gap_q[i] + GAP_H_X;
        assign hit_x_s    = (h_s >= x_q[i]) && (h_s < (x_q[i] + PIPE_W_X));
        assign lip_band_s = ((v_s >= (gap_q[i] - LIP_H_X)) && (v_s < gap_q[i])) ||
                            ((v_s >= gap_bot_s) && (v_s < (gap_bot_s + LIP_H_X)));
        assign lip_s[i]   = hit_x_s && lip_band_s;
        assign body_s[i]  = hit_x_s && ((v_s < gap_q[i]) || (v_s >= gap_bot_s));
    end

    // Game state machine; a freeze in RUN takes priority because start is ignored there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= start_i  ? RUN    : IDLE;
                RUN:     state_q <= freeze_i ? FREEZE : RUN;
                FREEZE:  state_q <= start_i  ? IDLE   : FREEZE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pipe positions, gap heights and the registered score event.
    always_ff @(posedge clk) begin
        if (rst || reinit_s) begin
            for (int i = 0; i < N_PIPES; i++) begin
                x_q[i]   <= x_init(i);
                gap_q[i] <= GAP_INIT_X;
            end
            score_pulse_q <= 1'b0;
        end else if (advance_s) begin
            for (int i = 0; i < N_PIPES; i++) begin
                x_q[i]   <= x_d[i];
                gap_q[i] <= gap_d[i];
            end
            score_pulse_q <= |score_hit_s;
        end else begin
            score_pulse_q <= 1'b0;
        end
    end

    // Stage 1: register timing, background and the OR-reduced per-pipe hit flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hcount_q <= 11'd0;
            s1_vcount_q <= 11'd0;
            s1_hsync_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_hblnk_q  <= 1'b0;
            s1_vblnk_q  <= 1'b0;
            s1_rgb_q    <= 12'h000;
            s1_lip_q    <= 1'b0;
            s1_body_q   <= 1'b0;
        end else begin
            s1_hcount_q <= vin_hcount_i;
            s1_vcount_q <= vin_vcount_i;
            s1_hsync_q  <= vin_hsync_i;
            s1_vsync_q  <= vin_vsync_i;
            s1_hblnk_q  <= vin_hblnk_i;
            s1_vblnk_q  <= vin_vblnk_i;
            s1_rgb_q    <= rgb_in_i;
            s1_lip_q    <= |lip_s;
            s1_body_q   <= |body_s;
        end
    end

    // Stage 2: composite; lips sit on top of bodies, blanking forces black.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_hcount_q <= 11'd0;
            s2_vcount_q <= 11'd0;
            s2_hsync_q  <= 1'b0;
            s2_vsync_q  <= 1'b0;
            s2_hblnk_q  <= 1'b0;
            s2_vblnk_q  <= 1'b0;
            s2_rgb_q    <= 12'h000;
            s2_px_q     <= 1'b0;
        end else begin
            s2_hcount_q <= s1_hcount_q;
            s2_vcount_q <= s1_vcount_q;
            s2_hsync_q  <= s1_hsync_q;
            s2_vsync_q  <= s1_vsync_q;
            s2_hblnk_q  <= s1_hblnk_q;
            s2_vblnk_q  <= s1_vblnk_q;
            if (s1_hblnk_q || s1_vblnk_q) begin
                s2_rgb_q <= 12'h000;
                s2_px_q  <= 1'b0;
            end else if (s1_lip_q) begin
                s2_rgb_q <= LIP_COLOR;
                s2_px_q  <= 1'b1;
            end else if (s1_body_q) begin
                s2_rgb_q <= PIPE_COLOR;
                s2_px_q  <= 1'b1;
            end else begin
                s2_rgb_q <= s1_rgb_q;
                s2_px_q  <= 1'b0;
            end
        end
    end

    assign vout_hcount_o = s2_hcount_q;
    assign vout_vcount_o = s2_vcount_q;
    assign vout_hsync_o  = s2_hsync_q;
    assign vout_vsync_o  = s2_vsync_q;
    assign vout_hblnk_o  = s2_hblnk_q;
    assign vout_vblnk_o  = s2_vblnk_q;
    assign rgb_out_o     = s2_rgb_q;
    assign pipe_px_o     = s2_px_q;
    assign score_pulse_o = score_pulse_q;

endmodule

// File: tb/tb_draw_pipes.sv
// Directed bench for draw_pipes: a behavioural game model feeds a scoreboard queue of
// expected pixels that is popped as the DUT's delayed output arrives.
`timescale 1ns/1ps
module tb_draw_pipes;

    logic        clk = 1'b0;
    logic        rst, start, freeze;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk;
    logic [11:0] rgb_in;
    logic [10:0] o_hcount, o_vcount;
    logic        o_hsync, o_vsync, o_hblnk, o_vblnk;
    logic [11:0] rgb_out;
    logic        pipe_px, score_pulse;

    always #5 clk = ~clk;

    draw_pipes dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .freeze_i      (freeze),
        .vin_hcount_i  (hcount),
        .vin_vcount_i  (vcount),
        .vin_hsync_i   (hsync),
        .vin_vsync_i   (vsync),
        .vin_hblnk_i   (hblnk),
        .vin_vblnk_i   (vblnk),
        .rgb_in_i      (rgb_in),
        .vout_hcount_o (o_hcount),
        .vout_vcount_o (o_vcount),
        .vout_hsync_o  (o_hsync),
        .vout_vsync_o  (o_vsync),
        .vout_hblnk_o  (o_hblnk),
        .vout_vblnk_o  (o_vblnk),
        .rgb_out_o     (rgb_out),
        .pipe_px_o     (pipe_px),
        .score_pulse_o (score_pulse)
    );

    typedef struct packed {
        logic [25:0] timing;
        logic [11:0] rgb;
        logic        px;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          mx[3];
    int          mgap[3];
    int          mstate;        // 0 idle, 1 run, 2 freeze
    logic [15:0] mlfsr;
    logic        mscore;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mx[i]   = 800 + i * 300;
            mgap[i] = 220;
        end
    endtask

    function automatic exp_t model_px(input int h, input int v, input logic [11:0] rgb);
        exp_t e;
        logic done;
        e.timing = {hcount, vcount, hsync, vsync, hblnk, vblnk};
        e.rgb    = rgb;
        e.px     = 1'b0;
        done     = 1'b0;
        if (hblnk || vblnk) begin
            e.rgb = 12'h000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!done && h >= mx[i] && h < mx[i] + 80) begin
                    if ((v >= mgap[i] - 16 && v < mgap[i]) ||
                        (v >= mgap[i] + 160 && v < mgap[i] + 176)) begin
                        e.rgb = 12'h070; e.px = 1'b1; done = 1'b1;
                    end else if (v < mgap[i] || v >= mgap[i] + 160) begin
                        e.rgb = 12'h0A0; e.px = 1'b1; done = 1'b1;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic model_edge(input int h, input int v);
        logic sc;
        int   nx;
        sc = 1'b0;
        if (mstate == 2 && start) begin
            model_reset();
        end else if (mstate == 1 && v == 600 && h == 0) begin
            for (int i = 0; i < 3; i++) begin
                nx = mx[i] - 2;
                if (nx + 80 <= 0) begin
                    mx[i]   = nx + 900;
                    mgap[i] = 80 + int'(mlfsr[7:0]);
                end else begin
                    if (mx[i] + 80 > 200 && nx + 80 <= 200) sc = 1'b1;
                    mx[i] = nx;
                end
            end
        end
        case (mstate)
            0:       mstate = start  ? 1 : 0;
            1:       mstate = freeze ? 2 : 1;
            2:       mstate = start  ? 0 : 2;
            default: mstate = 0;
        endcase
        mlfsr  = lfsr_next(mlfsr);
        mscore = sc;
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb);
        exp_t e;
        exp_t got;
        hcount = 11'(h);
        vcount = 11'(v);
        hsync  = h[3];
        vsync  = v[2];
        hblnk  = hb;
        vblnk  = vb;
        rgb_in = rgb;
        e = model_px(h, v, rgb);
        @(posedge clk);
        model_edge(h, v);
        sb_q.push_back(e);
        #1;
        if (sb_q.size() > 1) begin
            got = sb_q.pop_front();
            check("timing", int'({o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk}), int'(got.timing));
            check("rgb_out", int'(rgb_out), int'(got.rgb));
            check("pipe_px", int'(pipe_px), int'(got.px));
        end
        check("score_pulse", int'(score_pulse), int'(mscore));
    endtask

    task automatic tick();
        drive(0, 600, 1'b1, 1'b1, 12'($urandom_range(0, 4095)));
        drive(1, 600, 1'b1, 1'b1, 12'($urandom_range(0, 4095)));
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (mx[0] != target && n < 1500) begin
            tick();
            n++;
        end
        check("run_until_x0", int'(dut.x_q[0]), target);
    endtask

    // Body above, upper lip, gap, lower lip and body below for pipe 0.
    task automatic sweep(input int h0, input int cnt);
        int vs[5];
        vs[0] = mgap[0] - 20; vs[1] = mgap[0] - 8; vs[2] = mgap[0] + 50;
        vs[3] = mgap[0] + 165; vs[4] = mgap[0] + 200;
        for (int k = 0; k < 5; k++) begin
            for (int h = h0; h < h0 + cnt; h++) begin
                drive(h, vs[k], 1'b0, 1'b0, 12'($urandom_range(0, 4095)));
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        rst = 1'b1; start = 1'b0; freeze = 1'b0;
        hcount = 11'd5; vcount = 11'd5; hsync = 1'b1; vsync = 1'b1;
        hblnk = 1'b0; vblnk = 1'b0; rgb_in = 12'hABC;
        repeat (3) @(posedge clk);
        #1;
        // 1: reset state
        check("rst_timing", int'({o_hcount, o_vcount, o_hsync, o_vsync, o_hblnk, o_vblnk}), 0);
        check("rst_rgb", int'(rgb_out), 0);
        check("rst_px", int'(pipe_px), 0);
        check("rst_score", int'(score_pulse), 0);
        model_reset();
        mstate = 0; mlfsr = 16'hACE1; mscore = 1'b0;
        sb_q.delete();
        rst = 1'b0;
        check("rst_x0", int'(dut.x_q[0]), 800);
        check("rst_x1", int'(dut.x_q[1]), 1100);
        check("rst_x2", int'(dut.x_q[2]), 1400);
        drive(10, 10, 1'b0, 1'b0, 12'h123);
        repeat (3) tick();
        check("idle_x0", int'(dut.x_q[0]), 800);

        // 2: start, scroll 10 frames
        start = 1'b1;
        drive(20, 20, 1'b0, 1'b0, 12'h456);
        start = 1'b0;
        repeat (10) tick();
        check("x0_after_10", int'(dut.x_q[0]), 780);
        sweep(700, 100);

        // 3: score crossing
        run_until(122);
        tick();
        check("x0_score", int'(dut.x_q[0]), 120);
        drive(5, 5, 1'b0, 1'b0, 12'h321);
        check("score_one_clk", int'(score_pulse), 0);
        tick();
        check("x0_after_score", int'(dut.x_q[0]), 118);

        // frame 400: pipe 0 at the left edge
        run_until(0);
        sweep(0, 160);

        // 4: wrap-around with a fresh gap
        run_until(-78);
        tick();
        check("x0_wrap", int'(dut.x_q[0]), 820);
        g = int'(dut.gap_q[0]);
        check("gap_in_range", int'(g >= 80 && g <= 335), 1);
        check("gap_lfsr", g, mgap[0]);
        run_until(600);
        sweep(560, 160);

        // 5: freeze holds positions while still drawing
        freeze = 1'b1;
        drive(30, 30, 1'b0, 1'b0, 12'h777);
        freeze = 1'b0;
        repeat (5) tick();
        check("x0_frozen", int'(dut.x_q[0]), 600);
        sweep(560, 160);

        // 6: blanking over a pipe column
        for (int h = 580; h < 620; h++) drive(h, mgap[0] - 20, 1'b1, 1'b0, 12'hFFF);
        for (int h = 580; h < 620; h++) drive(h, mgap[0] + 200, 1'b0, 1'b1, 12'hFFF);
        check("blank_rgb", int'(rgb_out), 0);
        check("blank_px", int'(pipe_px), 0);

        start = 1'b1;
        drive(40, 40, 1'b0, 1'b0, 12'h111);
        start = 1'b0;
        check("restart_x0", int'(dut.x_q[0]), 800);
        check("restart_x2", int'(dut.x_q[2]), 1400);
        repeat (3) tick();
        check("restart_idle_x0", int'(dut.x_q[0]), 800);
        drive(50, 50, 1'b0, 1'b0, 12'h222);
        drive(51, 50, 1'b0, 1'b0, 12'h333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
